// File: rtl/quad_inverse_solver.sv
// Inverse of y = A*x^2 + B*x + C. Every W_X-bit candidate goes through one evaluator, one per cycle.
// The nearest candidate is kept, an exact match ends the sweep early, and the result is returned over valid/ready.
module quad_inverse_solver #(
   parameter int W_X = 4,
   parameter int W_Y = 8,
   parameter int A   = 1,
   parameter int B   = 10,
   parameter int C   = -10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W_Y-1:0] y_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W_X-1:0] x_out,
   output logic [W_Y:0]   err_out,
   output logic           exact
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   localparam logic [W_Y-1:0] A_T      = W_Y'(A);
   localparam logic [W_Y-1:0] B_T      = W_Y'(B);
   localparam logic [W_Y-1:0] C_T      = W_Y'(C);
   localparam logic [W_Y:0]   ERR_SENT = {1'b1, {W_Y{1'b0}}};
   localparam logic [W_X-1:0] IDX_MAX  = '1;

   // The low W_Y bits of sums and products depend only on the low W_Y bits of their operands.
   // Wrapping W_Y-bit arithmetic therefore equals full precision followed by truncation.
   function automatic logic [W_Y-1:0] quad(input logic [W_X-1:0] xi);
      logic [W_Y-1:0] xs;
      xs = W_Y'(signed'(xi));
      return A_T * xs * xs + B_T * xs + C_T;
   endfunction

   function automatic logic [W_Y:0] abs_err(input logic [W_Y-1:0] y, input logic [W_Y-1:0] q);
      logic [W_Y:0] diff;
      diff = {y[W_Y-1], y} - {q[W_Y-1], q};
      return diff[W_Y] ? (~diff + 1'b1) : diff;
   endfunction

   state_t         state_q, state_d;
   logic [W_Y-1:0] y_q, y_d;
   logic [W_X-1:0] idx_q, idx_d;
   logic           issue_done_q, issue_done_d;
   logic           pv_q, pv_d;
   logic [W_Y:0]   p_err_q, p_err_d;
   logic [W_X-1:0] p_x_q, p_x_d;
   logic           p_last_q, p_last_d;
   logic [W_X-1:0] best_x_q, best_x_d;
   logic [W_Y:0]   best_err_q, best_err_d;
   logic [W_X-1:0] x_out_q, x_out_d;
   logic [W_Y:0]   err_out_q, err_out_d;
   logic           exact_q, exact_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;

   logic [W_Y:0]   cand_err;
   logic [W_X-1:0] upd_x;
   logic [W_Y:0]   upd_err;

   always_comb begin
      cand_err = abs_err(y_q, quad(idx_q));
      // Strictly-less update: on ties the candidate visited first wins.
      if (pv_q && (p_err_q < best_err_q)) begin
         upd_x   = p_x_q;
         upd_err = p_err_q;
      end else begin
         upd_x   = best_x_q;
         upd_err = best_err_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      y_d          = y_q;
      idx_d        = idx_q;
      issue_done_d = issue_done_q;
      pv_d         = pv_q;
      p_err_d      = p_err_q;
      p_x_d        = p_x_q;
      p_last_d     = p_last_q;
      best_x_d     = best_x_q;
      best_err_d   = best_err_q;
      x_out_d      = x_out_q;
      err_out_d    = err_out_q;
      exact_d      = exact_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               y_d          = y_in;
               idx_d        = '0;
               issue_done_d = 1'b0;
               pv_d         = 1'b0;
               best_x_d     = '0;
               best_err_d   = ERR_SENT;
               state_d      = SWEEP;
            end
         end
         SWEEP: begin
            // Stage 1 registers the evaluator output so the multiply stays off the compare path.
            pv_d     = !issue_done_q;
            p_err_d  = cand_err;
            p_x_d    = idx_q;
            p_last_d = (idx_q == IDX_MAX);
            if (!issue_done_q) begin
               idx_d = idx_q + W_X'(1);
               if (idx_q == IDX_MAX)
                  issue_done_d = 1'b1;
            end
            // Stage 2: merge into the running best and decide whether to stop.
            if (pv_q) begin
               best_x_d   = upd_x;
               best_err_d = upd_err;
               if ((p_err_q == '0) || p_last_q) begin
                  state_d   = DONE;
                  pv_d      = 1'b0;
                  x_out_d   = upd_x;
                  err_out_d = upd_err;
                  exact_d   = (upd_err == '0);
               end
            end
         end
         DONE: begin
            if (out_valid_q && out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         y_q          <= '0;
         idx_q        <= '0;
         issue_done_q <= 1'b0;
         pv_q         <= 1'b0;
         p_err_q      <= '0;
         p_x_q        <= '0;
         p_last_q     <= 1'b0;
         best_x_q     <= '0;
         best_err_q   <= ERR_SENT;
         x_out_q      <= '0;
         err_out_q    <= '0;
         exact_q      <= 1'b0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         y_q          <= y_d;
         idx_q        <= idx_d;
         issue_done_q <= issue_done_d;
         pv_q         <= pv_d;
         p_err_q      <= p_err_d;
         p_x_q        <= p_x_d;
         p_last_q     <= p_last_d;
         best_x_q     <= best_x_d;
         best_err_q   <= best_err_d;
         x_out_q      <= x_out_d;
         err_out_q    <= err_out_d;
         exact_q      <= exact_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign x_out     = x_out_q;
   assign err_out   = err_out_q;
   assign exact     = exact_q;

endmodule

// File: tb/tb_quad_inverse_solver.sv
// Directed bench for quad_inverse_solver with default parameters (A=1, B=10, C=-10, W_X=4, W_Y=8).
module tb_quad_inverse_solver;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] y_in;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] x_out;
   logic [8:0] err_out;
   logic       exact;

   int errors = 0;
   int checks = 0;

   quad_inverse_solver dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .err_out   (err_out),
      .exact     (exact)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request for one edge; in_ready must be high at that edge.
   task automatic send(input string tag, input int y);
      check({tag, "_in_ready_idle"}, int'(in_ready), 1);
      in_valid = 1'b1;
      y_in     = 8'(y);
      tick();
      in_valid = 1'b0;
   endtask

   // Counts edges after the accepting edge until out_valid is seen.
   task automatic wait_valid(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
         if (lat == 1)
            check({tag, "_in_ready_busy"}, int'(in_ready), 0);
      end
      check({tag, "_latency"}, lat, exp_lat);
   endtask

   task automatic check_result(input string tag, input int ex, input int ee, input int exa);
      check({tag, "_x"}, int'(x_out), ex);
      check({tag, "_err"}, int'(err_out), ee);
      check({tag, "_exact"}, int'(exact), exa);
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, int'(out_valid), 0);
      check({tag, "_in_ready_back"}, int'(in_ready), 1);
   endtask

   task automatic run(input string tag, input int y, input int lat, input int ex, input int ee, input int exa);
      send(tag, y);
      wait_valid(tag, lat);
      check_result(tag, ex, ee, exa);
      consume(tag);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      y_in      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check_result("reset", 0, 0, 0);

      // Exact hits, nearest matches and ties
      run("y1",     1,    3, 1,  0,  1);
      run("y50",    50,   17, 4, 4,  0);
      run("y127",   127,  17, 7, 18, 0);
      run("ym34",   -34,  12, 10, 0, 1);
      run("ym33",   -33,  17, 10, 1, 0);
      run("ym128",  -128, 17, 11, 93, 0);

      // Back-to-back with out_ready held high: consumed the edge after DONE is entered
      out_ready = 1'b1;
      send("b2b_a", -128);
      wait_valid("b2b_a", 17);
      check_result("b2b_a", 11, 93, 0);
      tick();
      check("b2b_a_out_valid_drop", int'(out_valid), 0);
      send("b2b_b", 1);
      wait_valid("b2b_b", 3);
      check_result("b2b_b", 1, 0, 1);
      tick();
      check("b2b_b_out_valid_drop", int'(out_valid), 0);
      out_ready = 1'b0;

      // Backpressure: result held while in_valid pulses are ignored
      send("bp", 50);
      wait_valid("bp", 17);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         y_in     = 8'd1;
         tick();
         check($sformatf("bp_hold%0d_valid", i), int'(out_valid), 1);
         check_result($sformatf("bp_hold%0d", i), 4, 4, 0);
      end
      in_valid = 1'b0;
      consume("bp");
      tick();
      check("bp_no_capture", int'(in_ready), 1);

      // Reset while sweeping at idx 5
      send("rs", 50);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_in_ready", int'(in_ready), 1);
      check("rs_out_valid", int'(out_valid), 0);
      check_result("rs", 0, 0, 0);
      run("rs_after", 1, 3, 1, 0, 1);

      // Reset while a result waits in DONE
      send("rd", 50);
      wait_valid("rd", 17);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rd_out_valid", int'(out_valid), 0);
      out_ready = 1'b1;
      repeat (3) tick();
      check("rd_stays_idle_valid", int'(out_valid), 0);
      check("rd_stays_idle_ready", int'(in_ready), 1);
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
